// File: rtl/snoop_ctrl.sv
// snoop_ctrl: bus-side MSI snoop controller.
// Accepts one bus snoop at a time, probes the storage block's second tag port,
// owns the MSI state of every line, hands Modified-line flushes to the local
// cache controller and returns a snoop response to the bus.
//
// Ports:
//   clk, reset (sync, active-low)
//   snoop_val/snoop_rdy, snoop_type, snoop_addr   : bus snoop request
//   tag_read_en2, addr2, tag_tag, tag_match2       : tag probe to storage
//   st_wr_en, st_wr_idx, st_wr_state               : local state write
//   st_rd_idx, st_rd_state                         : local state read (comb)
//   flush_val/flush_rdy, flush_idx                 : flush request to local ctrl
//   resp_val/resp_rdy, resp_hit/shared/flush       : bus response
//   snoop_hits                                     : saturating hit counter
//
// state  | meaning
// IDLE   | ready for a new snoop
// LOOKUP | tag probe, hit decision, line state commit
// FLUSH  | waiting for local controller to take the flush
// RESP   | presenting response to the bus
module snoop_ctrl #(
    parameter int NLINES = 8,
    parameter int TAG_W  = 32,
    localparam int IDX_W = $clog2(NLINES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             snoop_val,
    output logic             snoop_rdy,
    input  logic [1:0]       snoop_type,
    input  logic [31:0]      snoop_addr,
    output logic             tag_read_en2,
    output logic [IDX_W-1:0] addr2,
    output logic [TAG_W-1:0] tag_tag,
    input  logic             tag_match2,
    input  logic             st_wr_en,
    input  logic [IDX_W-1:0] st_wr_idx,
    input  logic [1:0]       st_wr_state,
    input  logic [IDX_W-1:0] st_rd_idx,
    output logic [1:0]       st_rd_state,
    output logic             flush_val,
    input  logic             flush_rdy,
    output logic [IDX_W-1:0] flush_idx,
    output logic             resp_val,
    input  logic             resp_rdy,
    output logic             resp_hit,
    output logic             resp_shared,
    output logic             resp_flush,
    output logic [15:0]      snoop_hits
);

    typedef enum logic [1:0] {IDLE, LOOKUP, FLUSH, RESP} fsm_t;

    localparam logic [1:0] ST_I = 2'd0;
    localparam logic [1:0] ST_S = 2'd1;
    localparam logic [1:0] ST_M = 2'd2;

    localparam logic [1:0] T_BUSRD = 2'd0;
    localparam logic [1:0] T_RSVD  = 2'd3;

    fsm_t             fsm_q, fsm_d;
    logic [1:0]       type_q, type_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             hit_q, hit_d;
    logic             shared_q, shared_d;
    logic             flush_q, flush_d;
    logic [15:0]      snoop_hits_q, snoop_hits_d;
    logic [1:0]       line_q [NLINES];
    logic [1:0]       line_d [NLINES];

    logic [1:0]       cur_st;
    logic             lk_hit;
    logic             lk_was_m;
    logic [1:0]       lk_post;

    // Lookup decision; the illegal encoding 2'd3 behaves as I.
    always_comb begin
        cur_st   = (line_q[idx_q] == 2'd3) ? ST_I : line_q[idx_q];
        lk_hit   = tag_match2 && (cur_st != ST_I) && (type_q != T_RSVD);
        lk_was_m = (cur_st == ST_M);
        // BusRdX and BusUpgr both invalidate; BusUpgr on M is treated as BusRdX.
        lk_post  = (type_q == T_BUSRD) ? ST_S : ST_I;
    end

    always_comb begin
        fsm_d        = fsm_q;
        type_d       = type_q;
        idx_d        = idx_q;
        tag_d        = tag_q;
        hit_d        = hit_q;
        shared_d     = shared_q;
        flush_d      = flush_q;
        snoop_hits_d = snoop_hits_q;
        line_d       = line_q;

        if (st_wr_en) begin
            line_d[st_wr_idx] = st_wr_state;
        end

        case (fsm_q)
            IDLE: begin
                if (snoop_val) begin
                    type_d = snoop_type;
                    idx_d  = snoop_addr[4 +: IDX_W];
                    tag_d  = TAG_W'(snoop_addr >> (4 + IDX_W));
                    fsm_d  = LOOKUP;
                end
            end
            LOOKUP: begin
                hit_d    = lk_hit;
                shared_d = lk_hit && (lk_post == ST_S);
                flush_d  = lk_hit && lk_was_m;
                if (lk_hit) begin
                    // Written after the local write so the snoop commit wins.
                    line_d[idx_q] = lk_post;
                    if (snoop_hits_q != 16'hFFFF) begin
                        snoop_hits_d = snoop_hits_q + 16'd1;
                    end
                end
                fsm_d = (lk_hit && lk_was_m) ? FLUSH : RESP;
            end
            FLUSH: begin
                if (flush_rdy) begin
                    fsm_d = RESP;
                end
            end
            RESP: begin
                if (resp_rdy) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fsm_q        <= IDLE;
            type_q       <= 2'd0;
            idx_q        <= '0;
            tag_q        <= '0;
            hit_q        <= 1'b0;
            shared_q     <= 1'b0;
            flush_q      <= 1'b0;
            snoop_hits_q <= 16'd0;
            for (int i = 0; i < NLINES; i++) begin
                line_q[i] <= ST_I;
            end
        end else begin
            fsm_q        <= fsm_d;
            type_q       <= type_d;
            idx_q        <= idx_d;
            tag_q        <= tag_d;
            hit_q        <= hit_d;
            shared_q     <= shared_d;
            flush_q      <= flush_d;
            snoop_hits_q <= snoop_hits_d;
            for (int i = 0; i < NLINES; i++) begin
                line_q[i] <= line_d[i];
            end
        end
    end

    // Ready is suppressed while reset is being sampled low.
    assign snoop_rdy    = reset && (fsm_q == IDLE);
    assign tag_read_en2 = (fsm_q == LOOKUP);
    assign addr2        = idx_q;
    assign tag_tag      = tag_q;
    assign flush_val    = (fsm_q == FLUSH);
    assign flush_idx    = idx_q;
    assign resp_val     = (fsm_q == RESP);
    assign resp_hit     = resp_val && hit_q;
    assign resp_shared  = resp_val && shared_q;
    assign resp_flush   = resp_val && flush_q;
    assign snoop_hits   = snoop_hits_q;
    assign st_rd_state  = line_q[st_rd_idx];

endmodule
